music_sequencer: RTL and testbench
==================================

# music_sequencer

Song-level controller for the BRAM music player. It walks the song BRAM one note word at a time and presents each note code to the tone generator for a programmed number of tempo ticks, separated by a short silent gap. It handles play/pause/stop/loop control and end-of-song detection. It sits between the song BRAM and the tone generator / 7-segment display logic, replacing the free-running address counter.

## Interface
Parameters:
- ADDR_W, 4: song BRAM address width; song length up to 2^ADDR_W words.
- TICK_DIV, 3125000: clock cycles per tempo tick (8 ticks/s at 25 MHz).
- GAP_CYC, 250000: silent cycles between notes (10 ms at 25 MHz); legal range ≥1.

Ports:
- i_Clk  in  1  system clock (25 MHz).
- i_Rst_L  in  1  reset, asynchronous assert, active-low.
- i_Play  in  1  single-cycle pulse: start from IDLE/DONE, resume from PAUSE.
- i_Pause  in  1  single-cycle pulse: pause while playing.
- i_Stop  in  1  single-cycle pulse: abort and return to IDLE.
- i_Loop  in  1  level: restart at address 0 on end of song.
- o_ROM_Addr  out  ADDR_W  song BRAM read address.
- i_ROM_Data  in  16  BRAM read data, 1-cycle latency; [15:8] note code, [7:0] duration in ticks.
- o_Note  out  8  current note code to tone generator and display.
- o_Music_En  out  1  high while a note is sounding; gates the speaker output.
- o_Busy  out  1  high in every state except IDLE and DONE.
- o_Done  out  1  one-cycle pulse on entering DONE.

## Operation
- Reset values: state IDLE, o_ROM_Addr 0, o_Note 8'h00, o_Music_En 0, o_Busy 0, o_Done 0, all counters 0.
- Note codes: 8'h61 a … 8'h67 g, 8'h41/43/44/46/47 sharps, 8'h00 rest, 8'hFF end-of-song marker. The sequencer passes codes through unchanged and only interprets 8'hFF.
- States and transitions:
  - IDLE: i_Play → FETCH with address 0.
  - FETCH: address stable for one cycle → LOAD.
  - LOAD: i_ROM_Data valid; the register decides the next state.
    - Code 8'hFF at address ≠ 0: if i_Loop, address ← 0 → FETCH; otherwise → DONE.
    - Code 8'hFF at address 0 → DONE regardless of i_Loop (empty song, no spin).
    - Otherwise: o_Note ← code, dur ← duration (0 treated as 1), tick prescaler cleared → PLAY.
  - PLAY: o_Music_En = 1. Decrement dur on each tick. On the tick where dur = 1 → GAP.
  - GAP: o_Music_En = 0 and o_Note holds for GAP_CYC cycles. Then advance the address → FETCH.
    - If the address is 2^ADDR_W−1, this is an implicit end of song: i_Loop → address 0 → FETCH; otherwise → DONE.
  - PAUSE (entered from PLAY or GAP): o_Music_En = 0, prescaler/dur/gap counters frozen. i_Play → returns to the saved state with counters intact.
  - DONE: o_Music_En = 0, o_Note 8'h00, address held. i_Play → address 0 → FETCH.
- i_Stop in any state → IDLE on the next edge, with all outputs at reset values.
- Priority for simultaneous pulses: i_Stop > i_Pause > i_Play. i_Pause outside PLAY/GAP and i_Play in PLAY/GAP/FETCH/LOAD are ignored.
- i_Loop is sampled only at end-of-song decision points.

## Timing
- i_Play sampled at edge k from IDLE → FETCH after k, LOAD after k+1, o_Music_En high after k+2.
- Sounding time is exactly dur×TICK_DIV cycles of o_Music_En high, then exactly GAP_CYC low cycles.
- Next-note latency is 2 cycles (FETCH, LOAD): o_Music_En low for GAP_CYC+2 cycles between notes.
- Pause/resume: the sum of all PLAY-cycle counts is unchanged by pausing; resume re-asserts o_Music_En the cycle after the i_Play edge.
- Prescaler width is ceil(log2(TICK_DIV)); dur is 8-bit; gap counter width is ceil(log2(GAP_CYC+1)). All counters are free of overflow by construction.
- Reset asserted mid-note forces reset values asynchronously. Release is synchronous to i_Clk and the block starts in IDLE.

## Structure
- Shared package music_pkg holds:
  - note-code localparams (NOTE_A … NOTE_GS, NOTE_REST = 8'h00, NOTE_END = 8'hFF);
  - state encoding (IDLE, FETCH, LOAD, PLAY, GAP, PAUSE, DONE);
  - ROM word field positions.
- One sub-module, tempo_tick: TICK_DIV prescaler with clear and enable inputs, producing a one-cycle o_Tick.
- The FSM, address counter, dur counter and gap counter live in music_sequencer.

## Test plan
All scenarios use TICK_DIV=4, GAP_CYC=2, ADDR_W=4, modeled 1-cycle BRAM.
- Song {61/02, 63/01, FF}, i_Loop=0, i_Play pulse → o_Note 61 with o_Music_En high 8 cycles, low 4, then 63 high 4 cycles. Then o_Done pulses once and o_Busy drops.
- Same song with i_Loop=1 → after 63 the address returns to 0 and 61 replays. o_Done never pulses.
- i_Pause 3 cycles into the 61 note, held 10 cycles, then i_Play → o_Music_En low 10 cycles, then high for exactly 5 more cycles (8 total).
- i_Stop during GAP; also i_Stop and i_Play in the same cycle → IDLE, o_ROM_Addr 0, o_Note 00, o_Busy 0 next cycle.
- Word 0 = FF with i_Loop=1 → DONE after LOAD, o_Done pulse, no further fetches. Duration 0 word → sounds 4 cycles.
- 16 non-end words, i_Loop=0 → after address 15 gap, DONE. Reset asserted mid-PLAY → outputs at reset values immediately.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the BRAM music player: note codes, sequencer states
// and the layout of a song ROM word.
package music_pkg;

  localparam logic [7:0] NOTE_A    = 8'h61;
  localparam logic [7:0] NOTE_B    = 8'h62;
  localparam logic [7:0] NOTE_C    = 8'h63;
  localparam logic [7:0] NOTE_D    = 8'h64;
  localparam logic [7:0] NOTE_E    = 8'h65;
  localparam logic [7:0] NOTE_F    = 8'h66;
  localparam logic [7:0] NOTE_G    = 8'h67;
  localparam logic [7:0] NOTE_AS   = 8'h41;
  localparam logic [7:0] NOTE_CS   = 8'h43;
  localparam logic [7:0] NOTE_DS   = 8'h44;
  localparam logic [7:0] NOTE_FS   = 8'h46;
  localparam logic [7:0] NOTE_GS   = 8'h47;
  localparam logic [7:0] NOTE_REST = 8'h00;
  localparam logic [7:0] NOTE_END  = 8'hFF;

  localparam int unsigned ROM_W  = 16;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned DUR_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4,
    PAUSE = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Song word: note code in the upper byte, duration in ticks in the lower byte.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

endpackage

// File: rtl/tempo_tick.sv
// Tempo prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module tempo_tick #(
  parameter int unsigned TICK_DIV = 3125000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt <= '0;
    end else if (i_Clr) begin
      cnt <= '0;
    end else if (i_En) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Tick marks the last cycle of each period so the caller can act on that same edge.
  assign o_Tick = i_En && (cnt == CNT_LAST);

endmodule

// File: rtl/music_sequencer.sv
// Song-level controller: walks the song BRAM and presents each note to the tone
// generator for its programmed number of tempo ticks, with play/pause/stop/loop.
module music_sequencer
  import music_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned TICK_DIV = 3125000,
  parameter int unsigned GAP_CYC  = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Play,
  input  logic              i_Pause,
  input  logic              i_Stop,
  input  logic              i_Loop,
  output logic [ADDR_W-1:0] o_ROM_Addr,
  input  logic [ROM_W-1:0]  i_ROM_Data,
  output logic [7:0]        o_Note,
  output logic              o_Music_En,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t           state;
  state_t           state_nxt;
  state_t           saved;
  logic [DUR_W-1:0] dur;
  logic [GAP_W-1:0] gap_cnt;
  logic             tick;
  logic             play_end;
  logic             gap_end;
  logic             is_end;
  logic             music_en_d;
  logic             busy_d;
  logic             done_d;
  rom_word_t        word;

  assign word     = rom_word_t'(i_ROM_Data);
  assign is_end   = (word.code == NOTE_END);
  assign play_end = tick && (dur == DUR_W'(1));
  assign gap_end  = (gap_cnt == GAP_LAST);

  tempo_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tempo_tick (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Clr   (i_Stop || (state == LOAD)),
    .i_En    (state == PLAY),
    .o_Tick  (tick)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pause is too late on the final cycle of a note or gap; that edge completes normally.
  always_comb begin
    state_nxt = state;
    if (i_Stop) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (i_Play) state_nxt = FETCH;
        FETCH:   state_nxt = LOAD;
        LOAD: begin
          if (!is_end)                            state_nxt = PLAY;
          else if ((o_ROM_Addr != '0) && i_Loop)  state_nxt = FETCH;
          else                                    state_nxt = DONE;
        end
        PLAY: begin
          if (play_end)     state_nxt = GAP;
          else if (i_Pause) state_nxt = PAUSE;
        end
        GAP: begin
          if (gap_end)      state_nxt = ((o_ROM_Addr == ADDR_LAST) && !i_Loop) ? DONE : FETCH;
          else if (i_Pause) state_nxt = PAUSE;
        end
        PAUSE:   if (i_Play) state_nxt = saved;
        DONE:    if (i_Play) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    music_en_d = (state_nxt == PLAY);
    busy_d     = (state_nxt != IDLE) && (state_nxt != DONE);
    done_d     = (state_nxt == DONE) && (state != DONE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_ROM_Addr <= '0;
      o_Note     <= NOTE_REST;
      o_Music_En <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      dur        <= '0;
      gap_cnt    <= '0;
      saved      <= IDLE;
    end else begin
      o_Music_En <= music_en_d;
      o_Busy     <= busy_d;
      o_Done     <= done_d;
      if (i_Stop) begin
        o_ROM_Addr <= '0;
        o_Note     <= NOTE_REST;
        dur        <= '0;
        gap_cnt    <= '0;
        saved      <= IDLE;
      end else begin
        unique case (state)
          IDLE, DONE: if (i_Play) o_ROM_Addr <= '0;
          LOAD: begin
            if (is_end) begin
              if (state_nxt == FETCH) o_ROM_Addr <= '0;
            end else begin
              o_Note <= word.code;
              dur    <= (word.dur == '0) ? DUR_W'(1) : word.dur;
            end
          end
          PLAY: begin
            if (tick)                 dur   <= dur - DUR_W'(1);
            if (state_nxt == PAUSE)   saved <= PLAY;
          end
          GAP: begin
            if (gap_end) begin
              gap_cnt <= '0;
              if (o_ROM_Addr != ADDR_LAST) o_ROM_Addr <= o_ROM_Addr + ADDR_W'(1);
              else if (i_Loop)             o_ROM_Addr <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
            if (state_nxt == PAUSE) saved <= GAP;
          end
          default: ;
        endcase
        if (state_nxt == DONE) o_Note <= NOTE_REST;
      end
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Randomized and scenario-driven bench for music_sequencer against a
// cycle-count reference model of the song player.
module tb_music_sequencer;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned GAP_CYC  = 2;
  localparam int          N_WORDS  = 1 << ADDR_W;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_LOAD  = 2;
  localparam int M_SOUND = 3;
  localparam int M_GAP   = 4;
  localparam int M_DONE  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              play = 1'b0;
  logic              pause = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_q = 16'h0000;
  logic [7:0]        note;
  logic              music_en;
  logic              busy;
  logic              done;

  logic [15:0] rom [N_WORDS];
  logic [7:0]  codes [13] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67,
                              8'h41, 8'h43, 8'h44, 8'h46, 8'h47, 8'h00};

  int errors = 0;
  int checks = 0;

  // Reference model: song position plus cycles left in the current note or gap.
  int m_phase, m_addr, m_note, m_remain;
  bit m_paused, m_done;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  music_sequencer #(
    .ADDR_W   (ADDR_W),
    .TICK_DIV (TICK_DIV),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Play     (play),
    .i_Pause    (pause),
    .i_Stop     (stop),
    .i_Loop     (loop),
    .o_ROM_Addr (rom_addr),
    .i_ROM_Data (rom_q),
    .o_Note     (note),
    .o_Music_En (music_en),
    .o_Busy     (busy),
    .o_Done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_addr = 0; m_note = 0; m_remain = 0;
    m_paused = 0; m_done = 0;
  endtask

  task automatic model_finish();
    m_phase = M_DONE; m_note = 0; m_done = 1;
  endtask

  task automatic model_step(input bit p_play, input bit p_pause, input bit p_stop, input bit p_loop);
    logic [15:0] w;
    int d;
    m_done = 0;
    if (p_stop) begin
      model_reset();
      return;
    end
    if (m_paused) begin
      if (p_play) m_paused = 0;
      return;
    end
    case (m_phase)
      M_IDLE, M_DONE: if (p_play) begin m_phase = M_FETCH; m_addr = 0; end
      M_FETCH: m_phase = M_LOAD;
      M_LOAD: begin
        w = rom[m_addr];
        if (w[15:8] == 8'hFF) begin
          if (m_addr != 0 && p_loop) begin m_addr = 0; m_phase = M_FETCH; end
          else model_finish();
        end else begin
          d = int'(w[7:0]);
          if (d == 0) d = 1;
          m_note = int'(w[15:8]);
          m_remain = d * TICK_DIV;
          m_phase = M_SOUND;
        end
      end
      M_SOUND: begin
        m_remain--;
        if (m_remain == 0) begin m_phase = M_GAP; m_remain = GAP_CYC; end
        else if (p_pause) m_paused = 1;
      end
      M_GAP: begin
        m_remain--;
        if (m_remain == 0) begin
          if (m_addr != N_WORDS - 1) begin m_addr++; m_phase = M_FETCH; end
          else if (p_loop) begin m_addr = 0; m_phase = M_FETCH; end
          else model_finish();
        end else if (p_pause) m_paused = 1;
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input bit p_play, input bit p_pause, input bit p_stop);
    play = p_play; pause = p_pause; stop = p_stop;
    model_step(p_play, p_pause, p_stop, loop);
    @(negedge clk);
    check("addr", 32'(rom_addr), 32'(m_addr));
    check("note", 32'(note), 32'(m_note));
    check("music_en", 32'(music_en), 32'((m_phase == M_SOUND) && !m_paused));
    check("busy", 32'(busy), 32'((m_phase != M_IDLE) && (m_phase != M_DONE)));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges must clear the outputs before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_note", 32'(note), 32'd0);
    check("rst_music_en", 32'(music_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    play = 1'b0; pause = 1'b0; stop = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_rom(input int end_pct, input int max_dur);
    for (int i = 0; i < N_WORDS; i++) begin
      if ($urandom_range(0, 99) < end_pct) rom[i] = 16'hFF00;
      else rom[i] = {codes[$urandom_range(0, 12)], 8'($urandom_range(0, max_dur))};
    end
  endtask

  task automatic play_until_sound(input string tag);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      hit = (m_phase == M_SOUND) && !m_paused;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < N_WORDS; i++) rom[i] = 16'hFF00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Two-note song, no loop, then loop.
    rom[0] = 16'h6102; rom[1] = 16'h6301; rom[2] = 16'hFF00;
    loop = 1'b0;
    cycle(1'b1, 1'b0, 1'b0); idle(30);
    loop = 1'b1;
    cycle(1'b1, 1'b0, 1'b0); idle(50);
    async_reset();

    // Pause three cycles into the first note, resume ten cycles later.
    loop = 1'b0;
    cycle(1'b1, 1'b0, 1'b0); idle(4);
    cycle(1'b0, 1'b1, 1'b0); idle(9);
    cycle(1'b1, 1'b0, 1'b0); idle(25);

    // Stop during the gap, then stop and play together.
    cycle(1'b1, 1'b0, 1'b0); idle(10);
    cycle(1'b0, 1'b0, 1'b1); idle(2);
    cycle(1'b1, 1'b0, 1'b0); idle(3);
    cycle(1'b1, 1'b0, 1'b1); idle(3);

    // Empty song with loop set, then a zero-duration note.
    rom[0] = 16'hFF00; loop = 1'b1;
    cycle(1'b1, 1'b0, 1'b0); idle(8);
    rom[0] = 16'h6500; rom[1] = 16'hFF00; loop = 1'b0;
    cycle(1'b1, 1'b0, 1'b0); idle(14);

    // Full-length song runs off the end, then reset lands mid-note.
    fill_rom(0, 1);
    cycle(1'b1, 1'b0, 1'b0); idle(200);
    cycle(1'b1, 1'b0, 1'b0);
    play_until_sound("reach_play");
    idle(2);
    async_reset();
    idle(2);

    // Random songs and random control pulses.
    for (int ep = 0; ep < 20; ep++) begin
      fill_rom(12, 3);
      if (ep % 4 == 0) rom[0] = 16'hFF00;
      loop = 1'($urandom_range(0, 1));
      for (int c = 0; c < 300; c++) begin
        if (c % 60 == 59) loop = 1'($urandom_range(0, 1));
        cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 63) == 0));
      end
      if (ep % 5 == 4) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
